wb_trace_fifo: RTL and testbench
================================

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 Parameter: DWL, 32, register-file write-data width.
REQ-002 Parameter: AWL, 4, log2 of FIFO depth (DEPTH = 2**AWL = 16 entries).
REQ-003 Parameter: TSW, 16, timestamp width.
REQ-004 Port: CLK  in  1  the single clock; all state updates on the rising edge.
REQ-005 Port: RST  in  1  synchronous, active-high reset.
REQ-006 Port: RFWE  in  1  register-file write enable from the datapath.
REQ-007 Port: RFWA  in  5  register-file write address.
REQ-008 Port: RFWD  in  DWL  register-file write data (datapath writeback value).
REQ-009 Port: RdReq  in  1  consumer pop request.
REQ-010 Port: ClrOvf  in  1  clears overflow status.
REQ-011 Port: RdValid  out  1  one-cycle pulse: RdAddr/RdData/RdStamp hold a popped entry.
REQ-012 Port: RdAddr  out  5  popped register address.
REQ-013 Port: RdData  out  DWL  popped write data.
REQ-014 Port: RdStamp  out  TSW  popped cycle stamp.
REQ-015 Port: Empty  out  1  no entries stored.
REQ-016 Port: Full  out  1  DEPTH entries stored.
REQ-017 Port: Count  out  AWL+1  entries stored, 0..DEPTH.
REQ-018 Port: Overflow  out  1  sticky: at least one capture dropped.
REQ-019 Port: DropCnt  out  8  dropped captures, saturating at 255.

Function
REQ-020 Free-running TSW-bit cycle counter: 0 in the cycle after reset, +1 every cycle, wraps all-ones -> 0.
REQ-021 Capture event = RFWE=1 and RFWA!=0; writes to register 0 are never captured and never count as drops.
REQ-022 Capture with room (not Full, or Full with a pop in the same cycle) stores {RFWA, RFWD, current counter value} at the write pointer; pointer advances mod DEPTH.
REQ-023 Capture while Full and no pop in the same cycle: entry dropped, Overflow set to 1, DropCnt +1 (saturating at 255), FIFO contents unchanged.
REQ-024 Pop: RdReq=1 and not Empty; the oldest entry appears on RdAddr/RdData/RdStamp with RdValid=1 in the next cycle (1-cycle latency); read pointer advances mod DEPTH.
REQ-025 RdReq while Empty is ignored, including when a capture occurs in the same cycle (no fall-through); RdValid stays 0.
REQ-026 RdValid is high for exactly one cycle per pop; RdAddr/RdData/RdStamp hold their last popped values while RdValid=0.
REQ-027 Simultaneous accepted capture and pop leaves Count unchanged; capture only gives Count+1; pop only gives Count-1.
REQ-028 Empty = (Count==0); Full = (Count==DEPTH); both registered and consistent with Count in the same cycle.
REQ-029 ClrOvf=1 clears Overflow to 0 and DropCnt to 0; a drop in the same cycle takes priority: Overflow=1, DropCnt=1.
REQ-030 Entries are popped in capture order across pointer wrap-around.

Reset
REQ-031 While RST=1 at a clock edge: pointers 0, Count=0, Empty=1, Full=0, Overflow=0, DropCnt=0, RdValid=0, RdAddr=0, RdData=0, RdStamp=0, cycle counter=0.
REQ-032 Reset overrides captures, pops and ClrOvf in the same cycle; stored entries are discarded; reset mid-pop suppresses the pending RdValid.

Verification
REQ-033 Reset, then capture RFWA=5, RFWD=0xDEADBEEF in the third cycle after reset (counter=2), then RdReq -> next cycle RdValid=1, RdAddr=5, RdData=0xDEADBEEF, RdStamp=2; Empty=1.
REQ-034 RFWE=1 with RFWA=0 for 20 cycles -> Count=0, Overflow=0, DropCnt=0.
REQ-035 17 consecutive captures with no pops -> Full=1, Count=16, Overflow=1, DropCnt=1; 16 pops return the first 16 captures in order.
REQ-036 With Full=1, capture and RdReq in the same cycle -> Count stays 16, Overflow stays 0, the oldest entry is popped.
REQ-037 Capture 10, pop 10, capture 10, pop 10 (pointer wrap) -> data returned in order, Empty=1 at the end; 300 drops -> DropCnt=255; ClrOvf together with a drop -> Overflow=1, DropCnt=1.
REQ-038 RST asserted in the cycle after RdReq with Count=3 -> RdValid=0 in the next cycle and Count=0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Captures datapath register-file writebacks with a cycle stamp into a 16-deep trace FIFO.
// Pops return data one cycle after RdReq; a capture into a full FIFO without a same-cycle pop is dropped and counted.
module wb_trace_fifo #(
  parameter int DWL = 32,
  parameter int AWL = 4,
  parameter int TSW = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           RFWE,
  input  logic [4:0]     RFWA,
  input  logic [DWL-1:0] RFWD,
  input  logic           RdReq,
  input  logic           ClrOvf,
  output logic           RdValid,
  output logic [4:0]     RdAddr,
  output logic [DWL-1:0] RdData,
  output logic [TSW-1:0] RdStamp,
  output logic           Empty,
  output logic           Full,
  output logic [AWL:0]   Count,
  output logic           Overflow,
  output logic [7:0]     DropCnt
);

  localparam int DEPTH = 1 << AWL;
  localparam logic [AWL:0] FULL_CNT = (AWL+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]     addr;
    logic [DWL-1:0] data;
    logic [TSW-1:0] stamp;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AWL-1:0] wptr;
  logic [AWL-1:0] rptr;
  logic [TSW-1:0] stamp;

  logic           cap;
  logic           pop;
  logic           push;
  logic           drop;
  logic [AWL:0]   cnt_nxt;

  // A full FIFO still accepts a capture when a pop frees the slot in the same cycle.
  always_comb begin
    cap     = RFWE && (RFWA != 5'd0);
    pop     = RdReq && !Empty;
    push    = cap && (!Full || pop);
    drop    = cap && Full && !pop;
    cnt_nxt = Count;
    if (push && !pop)
      cnt_nxt = Count + 1'b1;
    else if (pop && !push)
      cnt_nxt = Count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push && !RST)
      mem[wptr] <= '{addr: RFWA, data: RFWD, stamp: stamp};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      stamp    <= '0;
      Count    <= '0;
      Empty    <= 1'b1;
      Full     <= 1'b0;
      Overflow <= 1'b0;
      DropCnt  <= '0;
      RdValid  <= 1'b0;
      RdAddr   <= '0;
      RdData   <= '0;
      RdStamp  <= '0;
    end else begin
      stamp   <= stamp + 1'b1;
      RdValid <= pop;
      Count   <= cnt_nxt;
      Empty   <= (cnt_nxt == '0);
      Full    <= (cnt_nxt == FULL_CNT);
      if (push)
        wptr <= wptr + 1'b1;
      if (pop) begin
        rptr                       <= rptr + 1'b1;
        {RdAddr, RdData, RdStamp}  <= mem[rptr];
      end
      // A drop wins over a same-cycle clear so the new loss is not hidden.
      if (drop) begin
        Overflow <= 1'b1;
        if (ClrOvf)
          DropCnt <= 8'd1;
        else if (DropCnt != 8'hFF)
          DropCnt <= DropCnt + 1'b1;
      end else if (ClrOvf) begin
        Overflow <= 1'b0;
        DropCnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed and randomized checks of wb_trace_fifo against a queue-based reference model.
module tb_wb_trace_fifo;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST, RFWE, RdReq, ClrOvf;
  logic [4:0]  RFWA;
  logic [31:0] RFWD;
  logic        RdValid, Empty, Full, Overflow;
  logic [4:0]  RdAddr;
  logic [31:0] RdData;
  logic [15:0] RdStamp;
  logic [4:0]  Count;
  logic [7:0]  DropCnt;

  wb_trace_fifo #(.DWL(32), .AWL(4), .TSW(16)) dut (
    .CLK(CLK), .RST(RST), .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
    .RdReq(RdReq), .ClrOvf(ClrOvf), .RdValid(RdValid), .RdAddr(RdAddr),
    .RdData(RdData), .RdStamp(RdStamp), .Empty(Empty), .Full(Full),
    .Count(Count), .Overflow(Overflow), .DropCnt(DropCnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [15:0] s;
  } ent_t;

  ent_t        q[$];
  ent_t        m_rd;
  int unsigned m_stamp;
  bit          m_ovf;
  int          m_drops;
  bit          m_rv;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] sent[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit cap, pop, full, drop;
    if (RST) begin
      q.delete();
      m_stamp = 0; m_ovf = 0; m_drops = 0; m_rv = 0;
      m_rd = '{5'd0, 32'd0, 16'd0};
    end else begin
      cap  = RFWE && (RFWA != 5'd0);
      full = (q.size() == DEPTH);
      pop  = RdReq && (q.size() != 0);
      drop = cap && full && !pop;
      m_rv = pop;
      if (pop) m_rd = q.pop_front();
      if (cap && !drop) q.push_back('{RFWA, RFWD, 16'(m_stamp)});
      if (drop) begin
        m_ovf   = 1;
        m_drops = ClrOvf ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (ClrOvf) begin
        m_ovf = 0; m_drops = 0;
      end
      m_stamp = (m_stamp + 1) % 65536;
    end
  endtask

  task automatic check_all();
    chk("rd_valid", RdValid, m_rv);
    chk("rd_addr", RdAddr, m_rd.a);
    chk("rd_data", RdData, m_rd.d);
    chk("rd_stamp", RdStamp, m_rd.s);
    chk("count", Count, q.size());
    chk("empty", Empty, q.size() == 0);
    chk("full", Full, q.size() == DEPTH);
    chk("overflow", Overflow, m_ovf);
    chk("drop_cnt", DropCnt, m_drops);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit rst, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input bit rr, input bit clr);
    RST = rst; RFWE = we; RFWA = wa; RFWD = wd; RdReq = rr; ClrOvf = clr;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 32'd0, 0, 0);
  endtask

  // Capture n random nonzero-address writes, recording their data.
  task automatic captures(input int n, input bit rr);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      drive(0, 1, 5'($urandom_range(1, 31)), d, rr, 0);
      sent.push_back(d);
      step();
    end
    idle();
  endtask

  task automatic pops(input int n, input string tag);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 5'd0, 32'd0, 1, 0);
      step();
      d = sent.pop_front();
      chk(tag, RdData, d);
    end
    idle();
  endtask

  initial begin
    drive(1, 0, 5'd0, 32'd0, 0, 0);
    step(); step();
    chk("reset_empty", Empty, 1'b1);
    chk("reset_count", Count, 5'd0);

    // Stamp 2 lands on the third edge after reset releases.
    idle(); step(); step();
    drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 0); step();
    drive(0, 0, 5'd0, 32'd0, 1, 0); step();
    chk("first_valid", RdValid, 1'b1);
    chk("first_addr", RdAddr, 5'd5);
    chk("first_data", RdData, 32'hDEADBEEF);
    chk("first_stamp", RdStamp, 16'd2);
    chk("first_empty", Empty, 1'b1);
    idle(); step();
    chk("valid_pulse", RdValid, 1'b0);
    chk("data_hold", RdData, 32'hDEADBEEF);

    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 5'd0, $urandom, 0, 0); step();
    end
    chk("r0_count", Count, 5'd0);
    chk("r0_ovf", Overflow, 1'b0);
    chk("r0_drops", DropCnt, 8'd0);

    captures(17, 0);
    void'(sent.pop_back());
    chk("fill_full", Full, 1'b1);
    chk("fill_count", Count, 5'd16);
    chk("fill_ovf", Overflow, 1'b1);
    chk("fill_drops", DropCnt, 8'd1);
    pops(16, "order16");
    chk("drained_empty", Empty, 1'b1);

    drive(0, 0, 5'd0, 32'd0, 0, 1); step();
    chk("clr_ovf", Overflow, 1'b0);
    captures(16, 0);
    captures(1, 1);
    chk("fullpop_count", Count, 5'd16);
    chk("fullpop_ovf", Overflow, 1'b0);
    chk("fullpop_data", RdData, sent.pop_front());
    pops(16, "after_fullpop");

    captures(10, 0); pops(10, "wrap_a");
    captures(10, 0); pops(10, "wrap_b");
    chk("wrap_empty", Empty, 1'b1);

    captures(16, 0);
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 5'd9, $urandom, 0, 0); step();
    end
    chk("sat_drops", DropCnt, 8'd255);
    drive(0, 1, 5'd9, 32'h1, 0, 1); step();
    chk("clr_drop_ovf", Overflow, 1'b1);
    chk("clr_drop_cnt", DropCnt, 8'd1);
    drive(0, 0, 5'd0, 32'd0, 0, 1); step();
    chk("clr_only_cnt", DropCnt, 8'd0);
    sent.delete();

    drive(1, 0, 5'd0, 32'd0, 0, 0); step();
    captures(3, 0);
    drive(1, 0, 5'd0, 32'd0, 1, 0); step();
    chk("rst_pop_valid", RdValid, 1'b0);
    chk("rst_pop_count", Count, 5'd0);
    sent.delete();
    captures(3, 0);
    drive(0, 0, 5'd0, 32'd0, 1, 0); step();
    drive(1, 0, 5'd0, 32'd0, 0, 0); step();
    chk("rst_after_valid", RdValid, 1'b0);
    chk("rst_after_count", Count, 5'd0);
    sent.delete();

    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
            5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
